// File: rtl/position_sched.sv
// ----------------------------------------------------------------------------
// position_sched
//
// Scans one frame of candidate pixels. Each detected corner is stored in the
// next free slot of an external position register file. After the last pixel,
// the stored corners are drained in slot order through a valid/ready port.
//
// FSM: IDLE -> COLLECT -> (DRAIN) -> DONE -> IDLE
//
// Ports
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   start                 one-cycle pulse, begins a frame scan (IDLE only)
//   pix_valid             ref_addr / mat_point / frame_end valid this cycle
//   ref_addr              address of the current candidate pixel
//   mat_point             current pixel is a corner
//   frame_end             current pixel is the last one of the frame
//   position              packed slots, slot 0 in the MSBs
//   out_ready             downstream accepts out_addr
//   wr_en/pos_addr/wr_addr    register-file write port (one pulse per corner)
//   pos_readen            register-file read enable (DRAIN)
//   out_valid/out_addr/out_idx   drained corner and its slot index
//   corner_cnt            corners stored this frame, 0..NUM_POS
//   overflow              sticky: a corner was dropped this frame
//   busy                  high outside IDLE
//   done                  one-cycle pulse at frame completion
// ----------------------------------------------------------------------------
module position_sched #(
    parameter int NUM_POS = 16,
    parameter int ADDR_W  = 15
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      pix_valid,
    input  logic [ADDR_W-1:0]         ref_addr,
    input  logic                      mat_point,
    input  logic                      frame_end,
    input  logic [NUM_POS*ADDR_W-1:0] position,
    input  logic                      out_ready,
    output logic                      wr_en,
    output logic [3:0]                pos_addr,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic                      pos_readen,
    output logic                      out_valid,
    output logic [ADDR_W-1:0]         out_addr,
    output logic [3:0]                out_idx,
    output logic [4:0]                corner_cnt,
    output logic                      overflow,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } stateT;

    stateT             state;
    stateT             nextState;
    logic              storeCorner;
    logic              dropCorner;
    logic              acceptOut;
    logic [ADDR_W-1:0] drainAddr;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and per-cycle decisions
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first; a missing
    // assignment on any path would otherwise infer a latch.
    always_comb begin
        nextState   = state;
        storeCorner = 1'b0;
        dropCorner  = 1'b0;
        acceptOut   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) nextState = COLLECT;
            end
            COLLECT: begin
                if (pix_valid && mat_point) begin
                    if (corner_cnt < 5'(NUM_POS)) storeCorner = 1'b1;
                    else                          dropCorner  = 1'b1;
                end
                // The last pixel's own corner counts toward the drain decision.
                if (pix_valid && frame_end) begin
                    nextState = (storeCorner || corner_cnt != 5'd0) ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    acceptOut = 1'b1;
                    if ({1'b0, out_idx} == corner_cnt - 5'd1) nextState = DONE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // NOTE: every control/data flop is reset so an abandoned frame leaves
    // no stale write strobe or count behind; the slot storage itself lives
    // outside this block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en      <= 1'b0;
            pos_addr   <= '0;
            wr_addr    <= '0;
            out_idx    <= '0;
            corner_cnt <= '0;
            overflow   <= 1'b0;
        end else begin
            wr_en <= storeCorner;
            if (storeCorner) begin
                pos_addr   <= corner_cnt[3:0];
                wr_addr    <= ref_addr;
                corner_cnt <= corner_cnt + 5'd1;
            end
            if (dropCorner) overflow <= 1'b1;
            if (state == IDLE && start) begin
                corner_cnt <= '0;
                overflow   <= 1'b0;
                out_idx    <= '0;
            end
            if (acceptOut) out_idx <= out_idx + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Drain read mux: slot i sits at bits [(NUM_POS-1-i)*ADDR_W +: ADDR_W]
    // ------------------------------------------------------------------
    always_comb begin
        drainAddr = '0;
        for (int i = 0; i < NUM_POS; i++) begin
            if (out_idx == 4'(i)) drainAddr = position[(NUM_POS-1-i)*ADDR_W +: ADDR_W];
        end
    end

    assign pos_readen = (state == DRAIN);
    assign out_valid  = (state == DRAIN);
    assign out_addr   = (state == DRAIN) ? drainAddr : '0;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

endmodule
